// File: rtl/ds_mod1.sv
// First-order error-feedback delta-sigma modulator: signed n-bit samples in,
// 1-bit pulse-density stream out, density (in + 2^(n-1)) / 2^n.
module ds_mod1 #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [n-1:0] in,
  output logic         out
);

  logic [n-1:0] u_s;
  logic [n:0]   sum_s;
  logic [n-1:0] acc_q;
  logic [n-1:0] acc_d;
  logic         out_q;
  logic         out_d;

  // Two's complement to offset binary is just an MSB flip.
  function automatic logic [n-1:0] offset_bin(input logic [n-1:0] x);
    logic [n-1:0] r;
    r        = x;
    r[n-1]   = ~x[n-1];
    return r;
  endfunction

  // Accumulate the offset sample; the carry out is the pulse, the wrapped sum is the residual error.
  always_comb begin
    u_s   = offset_bin(in);
    sum_s = {1'b0, acc_q} + {1'b0, u_s};
    acc_d = sum_s[n-1:0];
    out_d = sum_s[n];
  end

  // Accumulator and output register, cleared asynchronously while clr is low.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      acc_q <= {n{1'b0}};
      out_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_ds_mod1.sv
// Directed bench for ds_mod1 (n=4): reset behaviour, constant-input densities,
// boundary inputs and mid-stream input changes with a running-density bound.
module tb_ds_mod1;

  logic       clk;
  logic       clr;
  logic [3:0] in_s;
  logic       out_s;

  int checks;
  int failures;
  int ones;
  int sum_u;
  int err;

  ds_mod1 #(.n(4)) dut (
    .clk (clk),
    .clr (clr),
    .in  (in_s),
    .out (out_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] v);
    in_s = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2;
    clr = 1'b0;
    #1;
    chk("reset_out", {31'd0, out_s}, 32'd0);
    chk("reset_acc", {28'd0, dut.acc_q}, 32'd0);
    #1;
    clr = 1'b1;
  endtask

  logic [15:0] pat3;
  logic [3:0]  seg_in [4];
  int          seg_u  [4];

  initial begin
    checks   = 0;
    failures = 0;
    clr      = 1'b0;
    in_s     = 4'h0;
    #12;
    chk("por_out", {31'd0, out_s}, 32'd0);
    chk("por_acc", {28'd0, dut.acc_q}, 32'd0);
    clr = 1'b1;
    #1;

    // in=7 (u=15): first edge 0, then 15 ones; acc 15,14,13,...
    ones = 0;
    step(4'h7);
    chk("in7_first_out", {31'd0, out_s}, 32'd0);
    chk("in7_first_acc", {28'd0, dut.acc_q}, 32'd15);
    step(4'h7);
    chk("in7_acc2", {28'd0, dut.acc_q}, 32'd14);
    ones += out_s;
    for (int i = 2; i < 16; i++) begin
      step(4'h7);
      ones += out_s;
      chk("in7_out_one", {31'd0, out_s}, 32'd1);
    end
    chk("in7_ones16", ones, 32'd15);
    chk("in7_acc16", {28'd0, dut.acc_q}, 32'd0);

    // Mid-operation reset with acc nonzero and out high.
    step(4'h7);
    step(4'h7);
    step(4'h7);
    chk("pre_reset_acc", {28'd0, dut.acc_q}, 32'd13);
    chk("pre_reset_out", {31'd0, out_s}, 32'd1);
    do_reset();

    // in=0 (u=8): out 0,1,0,1..., acc 8,0,...
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      step(4'h0);
      ones += out_s;
      chk("in0_out", {31'd0, out_s}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("in0_acc", {28'd0, dut.acc_q}, (i % 2 == 1) ? 32'd0 : 32'd8);
    end
    chk("in0_ones16", ones, 32'd8);

    // in=-8 (u=0): out never rises, acc stays 0.
    do_reset();
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      step(4'h8);
      ones += out_s;
    end
    chk("inm8_ones16", ones, 32'd0);
    chk("inm8_acc", {28'd0, dut.acc_q}, 32'd0);

    // in=3 (u=11): acc 11,6,1,12,...; pattern listed edge 0 at bit 15.
    do_reset();
    pat3 = 16'b0110_1101_1011_0111;
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      step(4'h3);
      ones += out_s;
      chk("in3_out", {31'd0, out_s}, {31'd0, pat3[15-i]});
      if (i == 0) chk("in3_acc0", {28'd0, dut.acc_q}, 32'd11);
      if (i == 1) chk("in3_acc1", {28'd0, dut.acc_q}, 32'd6);
      if (i == 2) chk("in3_acc2", {28'd0, dut.acc_q}, 32'd1);
      if (i == 3) chk("in3_acc3", {28'd0, dut.acc_q}, 32'd12);
    end
    chk("in3_ones16", ones, 32'd11);
    chk("in3_acc16", {28'd0, dut.acc_q}, 32'd0);

    // Switching 7 -> -8 -> 0 -> 3 every 10 edges, no reset in between.
    // With acc starting at 0: 16*ones = sum_u - acc, so 0 <= sum_u - 16*ones <= 15.
    do_reset();
    seg_in[0] = 4'h7; seg_u[0] = 15;
    seg_in[1] = 4'h8; seg_u[1] = 0;
    seg_in[2] = 4'h0; seg_u[2] = 8;
    seg_in[3] = 4'h3; seg_u[3] = 11;
    ones  = 0;
    sum_u = 0;
    for (int s = 0; s < 4; s++) begin
      for (int e = 0; e < 10; e++) begin
        step(seg_in[s]);
        sum_u += seg_u[s];
        chk("sw_no_x", {31'd0, ^out_s === 1'bx}, 32'd0);
        ones += out_s;
        err = sum_u - 16 * ones;
        chk("sw_bound", {31'd0, (err >= 0) && (err <= 15)}, 32'd1);
      end
    end
    chk("sw_acc_final", {28'd0, dut.acc_q}, sum_u - 16 * ones);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
